// File: rtl/instruction_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words and writes them
// to instruction memory with a setup / strobe / release sequence, then raises start.
module instruction_loader #(
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int unsigned CNT_W      = 10,
    parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             write,
    output logic [31:0]      write_Instruction,
    output logic             write_Ready,
    output logic             start,
    output logic             busy,
    output logic             full,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {IDLE, COLLECT, SETUP, STROBE, RELEASE, DONE} state_t;

    // Internal count is one bit wider so reaching MAX_WORDS == 2**CNT_W cannot wrap;
    // the visible count saturates at its all-ones value in that corner.
    localparam logic [CNT_W:0] LAST    = (CNT_W+1)'(MAX_WORDS - 1);
    localparam logic [CNT_W:0] OUT_MAX = {1'b0, {CNT_W{1'b1}}};

    state_t         state, next_state;
    logic [1:0]     byte_idx;
    logic [31:0]    word, assembled;
    logic [CNT_W:0] count, count_n;
    logic           take;

    always_comb begin
        take      = (state == COLLECT) && byte_ready && byte_valid;
        count_n   = count + 1'b1;
        assembled = word;
        case (byte_idx)
            2'd0:    assembled[7:0]   = byte_data;
            2'd1:    assembled[15:8]  = byte_data;
            2'd2:    assembled[23:16] = byte_data;
            default: assembled[31:24] = byte_data;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_en) next_state = COLLECT;
            COLLECT: if (take && byte_idx == 2'd3)
                         next_state = (assembled == END_MARKER) ? DONE : SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  next_state = RELEASE;
            RELEASE: next_state = (count >= LAST) ? DONE : COLLECT;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so each is valid for the whole state;
    // write spans SETUP..RELEASE, keeping it clear of both write_Ready edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            byte_idx          <= '0;
            word              <= '0;
            count             <= '0;
            byte_ready        <= 1'b0;
            write             <= 1'b0;
            write_Instruction <= '0;
            write_Ready       <= 1'b0;
            start             <= 1'b0;
            busy              <= 1'b0;
            full              <= 1'b0;
            words_loaded      <= '0;
        end else begin
            state       <= next_state;
            byte_ready  <= (next_state == COLLECT) && load_en;
            write       <= (next_state == SETUP) || (next_state == STROBE) ||
                           (next_state == RELEASE);
            write_Ready <= (next_state == STROBE);
            start       <= (next_state == DONE);
            busy        <= (next_state != IDLE) && (next_state != DONE);
            if (take) begin
                word     <= assembled;
                byte_idx <= byte_idx + 2'd1;
            end
            if (next_state == SETUP)
                write_Instruction <= assembled;
            if (state == RELEASE) begin
                if (count <= LAST) begin
                    count        <= count_n;
                    words_loaded <= (count_n > OUT_MAX) ? '1 : count_n[CNT_W-1:0];
                end
                if (next_state == DONE)
                    full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized directed bench for instruction_loader against a word-list reference model.
module tb_instruction_loader;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, write, write_Ready, start, busy, full;
    logic [31:0] write_Instruction;
    logic [9:0]  words_loaded;

    instruction_loader #(.MAX_WORDS(MW), .CNT_W(10), .END_MARKER(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .write(write),
        .write_Instruction(write_Instruction), .write_Ready(write_Ready),
        .start(start), .busy(busy), .full(full), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] seen[$];
    logic [7:0]  stim[$];
    logic [31:0] exp_words[$];
    int          exp_used;
    bit          exp_full;
    logic        prev_wr = 1'b0, prev_w = 1'b0;
    logic [31:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: records each written word and checks write/strobe ordering.
    always @(negedge clk) begin
        if (rst) begin
            chk("write_in_reset", {63'd0, write}, 64'd0);
            prev_wr = 1'b0;
            prev_w  = 1'b0;
        end else begin
            if (write_Ready && !prev_wr) begin
                seen.push_back(write_Instruction);
                held = write_Instruction;
                chk("write_before_strobe", {63'd0, prev_w}, 64'd1);
            end
            if (write_Ready) begin
                chk("write_during_strobe", {63'd0, write}, 64'd1);
                chk("data_stable", {32'd0, write_Instruction}, {32'd0, held});
            end
            if (write != prev_w)
                chk("write_vs_strobe_edge", {63'd0, write_Ready}, {63'd0, prev_wr});
            prev_wr = write_Ready;
            prev_w  = write;
        end
    end

    // Reference: split the stream into LE words; stop at the marker or at MW writes.
    task automatic model();
        logic [31:0] w;
        exp_words.delete();
        exp_used = 0;
        exp_full = 0;
        for (int i = 0; i + 3 < stim.size(); i += 4) begin
            w = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
            exp_used = i + 4;
            if (w == 32'hFFFF_FFFF) break;
            exp_words.push_back(w);
            if (exp_words.size() == MW) begin
                exp_full = 1;
                break;
            end
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stim.push_back(8'(w >> (8*i)));
    endtask

    task automatic build(input int k);
        logic [31:0] w;
        stim.delete();
        for (int i = 0; i < k; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            push_word(w);
        end
        push_word(32'hFFFF_FFFF);
    endtask

    task automatic pulse_reset();
        rst = 1'b1; load_en = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            {22'd0, byte_ready, write, write_Ready, start, busy, full, words_loaded, write_Instruction},
            64'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready) begin
            ok = 1;
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic do_load(input bit do_rst, input bit gaps, input int pause_at);
        bit ok;
        int n;
        model();
        if (do_rst) pulse_reset();
        seen.delete();
        load_en = 1'b1;
        for (int i = 0; i < exp_used; i++) begin
            if (i == pause_at) begin
                load_en = 1'b0;
                repeat (5) @(negedge clk);
                chk("paused_ready", {63'd0, byte_ready}, 64'd0);
                load_en = 1'b1;
            end
            send_byte(stim[i], ok);
            chk("byte_accepted", {63'd0, ok}, 64'd1);
            if (gaps) @(negedge clk);
        end
        n = 0;
        while (!start && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("start", {63'd0, start}, 64'd1);
        chk("strobe_count", seen.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < seen.size(); i++)
            chk("word", {32'd0, seen[i]}, {32'd0, exp_words[i]});
        chk("words_loaded", {54'd0, words_loaded}, exp_words.size());
        chk("full", {63'd0, full}, {63'd0, exp_full});
        chk("done_flags", {61'd0, byte_ready, busy, write}, 64'd0);
        if (exp_used < stim.size()) begin
            byte_valid = 1'b1;
            byte_data  = stim[exp_used];
            repeat (5) @(negedge clk);
            chk("ready_after_done", {63'd0, byte_ready}, 64'd0);
            byte_valid = 1'b0;
            chk("no_extra_strobe", seen.size(), exp_words.size());
        end
    endtask

    initial begin
        bit          ok;
        int          n;
        logic [31:0] w1, w2;

        repeat (2) @(negedge clk);

        // Single word then marker.
        stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load(1, 0, -1);

        // Byte ordering.
        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load(1, 0, -1);

        // Gapped valid plus a load_en pause mid-word.
        build(3);
        do_load(1, 1, 6);

        // Capacity limit: six words offered, MW written.
        build(6);
        do_load(1, 0, -1);

        // Marker as the first word.
        build(0);
        do_load(1, 0, -1);

        // Reset during the strobe of word 2, then reload without another reset.
        pulse_reset();
        seen.delete();
        w1 = $urandom & 32'h7FFF_FFFF;
        w2 = $urandom & 32'h7FFF_FFFF;
        stim.delete();
        push_word(w1);
        push_word(w2);
        load_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_byte(stim[i], ok);
            chk("byte_accepted", {63'd0, ok}, 64'd1);
        end
        n = 0;
        while (!(write_Ready && words_loaded == 10'd1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_strobe2", {63'd0, write_Ready}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            {22'd0, byte_ready, write, write_Ready, start, busy, full, words_loaded, write_Instruction},
            64'd0);
        chk("strobe2_seen", seen.size(), 2);
        if (seen.size() == 2) chk("strobe2_word", {32'd0, seen[1]}, {32'd0, w2});
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        build(2);
        do_load(0, 0, -1);

        // Randomized loads.
        for (int t = 0; t < 8; t++) begin
            build(int'($urandom_range(0, 6)));
            do_load(1, bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? 2 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
